// File: rtl/pipeline_readreg_stage.sv
// -----------------------------------------------------------------------------
// pipeline_readreg_stage
//   Register-read pipeline stage between decode and execute. It holds one
//   instruction (control bundle, register numbers and immediate) behind a
//   valid/ready handshake with stall and flush. It also owns the
//   NREAD-read / 1-write register file, which is written by the final
//   stage's writeback. Reads are write-first, so a value being written back
//   this cycle is visible on rdata in the same cycle.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   flush               kill the instruction held in this stage
//   control_in, readnum_in, imm_in   instruction fields from decode
//   write/writenum/writedata         writeback port into the register file
//   out_valid/out_ready downstream handshake
//   control_out         latched control, zero while the stage holds a bubble
//   readnum_out, imm_out             latched register numbers / immediate
//   rdata               per-port read data, port k at [k*DATA_W +: DATA_W]
//   reg_dump            every register, reg i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module pipeline_readreg_stage #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned NREGS  = 8,
    parameter  int unsigned NREAD  = 3,
    parameter  int unsigned CTRL_W = 22,
    localparam int unsigned RA_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic [CTRL_W-1:0]       control_in,
    input  logic [NREAD*RA_W-1:0]   readnum_in,
    input  logic [DATA_W-1:0]       imm_in,
    input  logic                    write,
    input  logic [RA_W-1:0]         writenum,
    input  logic [DATA_W-1:0]       writedata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       control_out,
    output logic [NREAD*RA_W-1:0]   readnum_out,
    output logic [DATA_W-1:0]       imm_out,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREGS*DATA_W-1:0] reg_dump
);

    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [NREAD*RA_W-1:0] rnum_q;
    logic [DATA_W-1:0]     imm_q;
    logic [DATA_W-1:0]     regs_q [NREGS];
    logic                  accept;

    // Handshake and occupancy next state (flush beats accept beats drain)
    always_comb begin
        in_ready = !valid_q || out_ready;
        accept   = in_valid && in_ready;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline latch and register file; writeback ignores handshake/flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rnum_q  <= '0;
            imm_q   <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                ctrl_q <= control_in;
                rnum_q <= readnum_in;
                imm_q  <= imm_in;
            end
            if (write) begin
                regs_q[writenum] <= writedata;
            end
        end
    end

    // Write-first read ports; bypass does not depend on out_valid
    for (genvar k = 0; k < int'(NREAD); k++) begin : g_read
        logic [RA_W-1:0] num;
        assign num = rnum_q[k*RA_W +: RA_W];
        assign rdata[k*DATA_W +: DATA_W] =
            (write && (writenum == num)) ? writedata : regs_q[num];
    end

    for (genvar i = 0; i < int'(NREGS); i++) begin : g_dump
        assign reg_dump[i*DATA_W +: DATA_W] = regs_q[i];
    end

    // A bubble presents an all-zero control word, i.e. a NOP downstream
    assign out_valid   = valid_q;
    assign control_out = valid_q ? ctrl_q : '0;
    assign readnum_out = rnum_q;
    assign imm_out     = imm_q;

endmodule
